// File: rtl/trainer_truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : trainer_truth_table_scanner
//  Description : Drives the trainer gate stage through all four a/b input
//                combinations and holds each one for SETTLE_CYCLES cycles
//                before sampling y. It builds the 4-bit truth table, compares
//                it with the expected table for the selected gate and reports
//                the result as fail_mask and match.
//  Revision    : 1.0 - initial release
// ============================================================================
module trainer_truth_table_scanner #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [2:0] sel_in,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic [2:0] sel_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_out,
  output logic [3:0] fail_mask,
  output logic       match
);

  // Final count value of the settle phase. The counter is 8 bits wide,
  // so SETTLE_CYCLES can range from 1 to 255.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] SEL_INVALID = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic [3:0] table_q, table_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       start_rise;
  logic [3:0] expected;

  assign start_rise = start & ~start_q;

  // Register all scan state. Reset discards any partial table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      sel_q   <= 3'b000;
      idx_q   <= 2'b00;
      cnt_q   <= 8'd0;
      ab_q    <= 2'b00;
      table_q <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Compute the next state and the scan datapath. A low ena overrides every
  // state but leaves the latched select unchanged.
  always_comb begin
    state_d = state_q;
    start_d = start;
    sel_d   = sel_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    table_d = table_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (!ena) begin
      state_d = ST_IDLE;
      idx_d   = 2'b00;
      cnt_d   = 8'd0;
      ab_d    = 2'b00;
      table_d = 4'b0000;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_rise) begin
            state_d = ST_DRIVE;
            sel_d   = sel_in;
            idx_d   = 2'b00;
            cnt_d   = 8'd0;
            ab_d    = 2'b00;
            table_d = 4'b0000;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_SAMPLE: begin
          table_d[idx_q] = y_in;
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            idx_d   = idx_q + 2'd1;
            ab_d    = idx_q + 2'd1;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Look up the reference truth table for the latched gate. Bit index is
  // {a,b}, so bit 3 holds the a=1, b=1 result.
  always_comb begin
    expected = 4'b0000;
    case (sel_q)
      3'b000:  expected = 4'b1000;  // AND
      3'b001:  expected = 4'b1110;  // OR
      3'b010:  expected = 4'b0111;  // NAND
      3'b011:  expected = 4'b0001;  // NOR
      3'b100:  expected = 4'b0110;  // XOR
      3'b101:  expected = 4'b1001;  // XNOR
      3'b110:  expected = 4'b0011;  // NOT a
      default: expected = 4'b0000;  // invalid select
    endcase
  end

  assign a_out     = ab_q[1];
  assign b_out     = ab_q[0];
  assign sel_out   = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign fail_mask = done_q ? (table_q ^ expected) : 4'b0000;
  assign match     = done_q && (fail_mask == 4'b0000) && (sel_q != SEL_INVALID);

endmodule
`default_nettype wire

// File: tb/tb_trainer_truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trainer_truth_table_scanner
//  Description : Directed bench for the truth-table scanner. It includes a
//                behavioural gate stage with optional stuck-at faults, a
//                default-settle instance and a SETTLE_CYCLES=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trainer_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [2:0] sel_in;
  logic [1:0] fault;  // 0 good gate, 1 y stuck at 0, 2 y stuck at 1

  logic       y1, a1, b1, busy1, done1, m1;
  logic [2:0] sel1;
  logic [3:0] tab1, fm1;
  logic       y2, a2, b2, busy2, done2, m2;
  logic [2:0] sel2;
  logic [3:0] tab2, fm2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trainer_truth_table_scanner u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sel_in(sel_in),
    .y_in(y1), .a_out(a1), .b_out(b1), .sel_out(sel1), .busy(busy1),
    .done(done1), .table_out(tab1), .fail_mask(fm1), .match(m1)
  );

  trainer_truth_table_scanner #(.SETTLE_CYCLES(1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sel_in(sel_in),
    .y_in(y2), .a_out(a2), .b_out(b2), .sel_out(sel2), .busy(busy2),
    .done(done2), .table_out(tab2), .fail_mask(fm2), .match(m2)
  );

  function automatic logic gate(input logic [2:0] s, input logic a,
                                input logic b, input logic [1:0] f);
    if (f == 2'd1) return 1'b0;
    if (f == 2'd2) return 1'b1;
    case (s)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return ~(a & b);
      3'b011:  return ~(a | b);
      3'b100:  return a ^ b;
      3'b101:  return ~(a ^ b);
      3'b110:  return ~a;
      default: return 1'b0;
    endcase
  endfunction

  always_comb y1 = gate(sel1, a1, b1, fault);
  always_comb y2 = gate(sel2, a2, b2, fault);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue a one-cycle start, then count cycles after E0 until done.
  task automatic run_scan(input logic [2:0] s, input bit check_ab, output int lat);
    @(negedge clk);
    sel_in = s;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    chk("busy_after_start", 32'(busy1), 32'd1);
    chk("sel_latched", 32'(sel1), 32'(s));
    while (!done1 && lat < 60) begin
      if (check_ab) chk("ab_step", 32'({a1, b1}), 32'(lat / 5));
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [1:0] fault;
    logic [3:0] tab;
    logic [3:0] mask;
    logic       m;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;

    vecs[0]  = '{3'b000, 2'd0, 4'b1000, 4'b0000, 1'b1};
    vecs[1]  = '{3'b001, 2'd0, 4'b1110, 4'b0000, 1'b1};
    vecs[2]  = '{3'b010, 2'd0, 4'b0111, 4'b0000, 1'b1};
    vecs[3]  = '{3'b011, 2'd0, 4'b0001, 4'b0000, 1'b1};
    vecs[4]  = '{3'b100, 2'd0, 4'b0110, 4'b0000, 1'b1};
    vecs[5]  = '{3'b101, 2'd0, 4'b1001, 4'b0000, 1'b1};
    vecs[6]  = '{3'b110, 2'd0, 4'b0011, 4'b0000, 1'b1};
    vecs[7]  = '{3'b111, 2'd0, 4'b0000, 4'b0000, 1'b0};
    vecs[8]  = '{3'b001, 2'd1, 4'b0000, 4'b1110, 1'b0};
    vecs[9]  = '{3'b000, 2'd1, 4'b0000, 4'b1000, 1'b0};
    vecs[10] = '{3'b110, 2'd2, 4'b1111, 4'b1100, 1'b0};

    rst_n  = 1'b0;
    ena    = 1'b1;
    start  = 1'b0;
    sel_in = 3'b000;
    fault  = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_ab", 32'({a1, b1}), 32'd0);
    chk("rst_table", 32'(tab1), 32'd0);
    chk("rst_match", 32'(m1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy1), 32'd0);

    // Run each table entry as a full scan.
    for (int i = 0; i < 11; i++) begin
      fault = vecs[i].fault;
      run_scan(vecs[i].sel, i == 0, lat);
      chk("done_latency", 32'(lat), 32'd20);
      chk("table", 32'(tab1), 32'(vecs[i].tab));
      chk("fail_mask", 32'(fm1), 32'(vecs[i].mask));
      chk("match", 32'(m1), 32'(vecs[i].m));
      chk("busy_at_done", 32'(busy1), 32'd0);
      chk("ab_held_11", 32'({a1, b1}), 32'd3);
    end
    fault = 2'd0;

    // A second start during the scan is ignored.
    @(negedge clk);
    sel_in = 3'b101;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    repeat (6) begin @(negedge clk); k++; end
    sel_in = 3'b010;
    start  = 1'b1;
    @(negedge clk);
    k++;
    start = 1'b0;
    chk("mid_scan_busy", 32'(busy1), 32'd1);
    while (!done1 && k < 60) begin @(negedge clk); k++; end
    chk("ignored_start_latency", 32'(k), 32'd20);
    chk("ignored_start_sel", 32'(sel1), 32'b101);
    chk("ignored_start_table", 32'(tab1), 32'b1001);
    chk("ignored_start_match", 32'(m1), 32'd1);

    // Holding start high produces a single scan.
    @(negedge clk);
    sel_in = 3'b000;
    start  = 1'b1;
    @(negedge clk);
    k = 0;
    while (!done1 && k < 60) begin @(negedge clk); k++; end
    chk("held_start_latency", 32'(k), 32'd20);
    repeat (10) @(negedge clk);
    chk("held_start_no_rescan", 32'(busy1), 32'd0);
    chk("held_start_done_kept", 32'(done1), 32'd1);
    start = 1'b0;

    // A low ena aborts the scan; the latched select is kept.
    @(negedge clk);
    sel_in = 3'b001;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_table", 32'(tab1), 32'd0);
    chk("abort_ab", 32'({a1, b1}), 32'd0);
    chk("abort_sel_kept", 32'(sel1), 32'b001);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_not_queued", 32'(busy1), 32'd0);
    run_scan(3'b001, 1'b0, lat);
    chk("after_abort_latency", 32'(lat), 32'd20);
    chk("after_abort_table", 32'(tab1), 32'b1110);
    chk("after_abort_match", 32'(m1), 32'd1);

    // Asynchronous reset between clock edges mid-scan.
    @(negedge clk);
    sel_in = 3'b100;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_busy", 32'(busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy1), 32'd0);
    chk("async_rst_ab", 32'({a1, b1}), 32'd0);
    chk("async_rst_sel", 32'(sel1), 32'd0);
    chk("async_rst_table", 32'(tab1), 32'd0);
    chk("async_rst_fast_done", 32'(done2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Compare the SETTLE_CYCLES=1 instance with the default instance.
    sel_in = 3'b100;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done2 && k < 60) begin @(negedge clk); k++; end
    chk("fast_latency", 32'(k), 32'd8);
    chk("fast_table", 32'(tab2), 32'b0110);
    chk("fast_mask", 32'(fm2), 32'd0);
    chk("fast_match", 32'(m2), 32'd1);
    chk("slow_still_busy", 32'(busy1), 32'd1);
    while (!done1 && k < 60) begin @(negedge clk); k++; end
    chk("slow_latency", 32'(k), 32'd20);
    chk("slow_table", 32'(tab1), 32'b0110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
